// File: rtl/tft_top.sv
// SPI bring-up and full-screen fill for an RGB565 TFT panel: hardware reset, sleep-out,
// pixel format/orientation, address window, then one colour (or colour bars with TFT_COLOR_BAR_EN).
module tft_top #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned SCK_HALF     = 2,
    parameter int unsigned RST_LOW_CYC  = 1_000,
    parameter int unsigned RST_WAIT_CYC = 250_000,
    parameter int unsigned SLP_WAIT_CYC = 250_000,
    parameter logic [15:0] FILL_COLOR   = 16'hF800,
    parameter int unsigned FILL_COLS    = 240,
    parameter int unsigned FILL_ROWS    = 320
) (
    input  logic clk,
    input  logic rst,
    output logic tft_cs,
    output logic tft_sck,
    output logic tft_rst,
    output logic tft_dc,
    output logic tft_mosi
);

    localparam int unsigned CW = (FILL_COLS > 1) ? $clog2(FILL_COLS) : 1;
    localparam int unsigned RW = (FILL_ROWS > 1) ? $clog2(FILL_ROWS) : 1;

    if (CLK_HZ == 0 || SCK_HALF == 0) begin : g_cfg_check
        $error("tft_top: CLK_HZ and SCK_HALF must be non-zero");
    end

    typedef enum logic [2:0] {
        StRstLow, StRstWait, StSleepOut, StSlpWait, StInit, StWindow, StFill, StDone
    } state_t;

    state_t          state;
    logic [31:0]     cnt;
    logic [3:0]      idx;
    logic            pix_lo;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            busy;
    logic [4:0]      slot;
    logic [7:0]      hcnt;
    logic [6:0]      shift;

    logic [7:0]  tx_byte;
    logic        tx_dc;
    logic [15:0] pix_color;
    logic        send_state, step, cs_rise, tail_end, start;

`ifdef TFT_COLOR_BAR_EN
    logic [2:0] bar;
    always_comb begin
        bar = 3'(col / CW'(30));
        case (bar)
            3'd0:    pix_color = 16'hFFFF;
            3'd1:    pix_color = 16'hFFE0;
            3'd2:    pix_color = 16'h07FF;
            3'd3:    pix_color = 16'h07E0;
            3'd4:    pix_color = 16'hF81F;
            3'd5:    pix_color = 16'hF800;
            3'd6:    pix_color = 16'h001F;
            default: pix_color = 16'h0000;
        endcase
    end
`else
    assign pix_color = FILL_COLOR;
`endif

    always_comb begin
        tx_byte = 8'h00;
        tx_dc   = 1'b0;
        case (state)
            StSleepOut: tx_byte = 8'h11;
            StInit: begin
                case (idx)
                    4'd0:    tx_byte = 8'h3A;
                    4'd1:    tx_byte = 8'h55;
                    4'd2:    tx_byte = 8'h36;
                    4'd3:    tx_byte = 8'h48;
                    default: tx_byte = 8'h29;
                endcase
                tx_dc = (idx == 4'd1) || (idx == 4'd3);
            end
            StWindow: begin
                case (idx)
                    4'd0:    tx_byte = 8'h2A;
                    4'd4:    tx_byte = 8'hEF;
                    4'd5:    tx_byte = 8'h2B;
                    4'd8:    tx_byte = 8'h01;
                    4'd9:    tx_byte = 8'h3F;
                    4'd10:   tx_byte = 8'h2C;
                    default: tx_byte = 8'h00;
                endcase
                tx_dc = !((idx == 4'd0) || (idx == 4'd5) || (idx == 4'd10));
            end
            StFill: begin
                tx_byte = pix_lo ? pix_color[7:0] : pix_color[15:8];
                tx_dc   = 1'b1;
            end
            default: ;
        endcase
    end

    // Slots are SCK_HALF long: 0 setup, 1..16 bit high/low halves, 17..18 cs-high gap.
    assign send_state = (state == StSleepOut) || (state == StInit) ||
                        (state == StWindow) || (state == StFill);
    assign step     = busy && (hcnt == 8'(SCK_HALF - 1));
    assign cs_rise  = step && (slot == 5'd16);
    assign tail_end = step && (slot == 5'd18);
    assign start    = send_state && (!busy || tail_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StRstLow;
            cnt      <= '0;
            idx      <= '0;
            pix_lo   <= 1'b0;
            col      <= '0;
            row      <= '0;
            busy     <= 1'b0;
            slot     <= '0;
            hcnt     <= '0;
            shift    <= '0;
            tft_cs   <= 1'b1;
            tft_sck  <= 1'b0;
            tft_rst  <= 1'b0;
            tft_dc   <= 1'b0;
            tft_mosi <= 1'b0;
        end else begin
            if (start) begin
                busy     <= 1'b1;
                slot     <= '0;
                hcnt     <= '0;
                tft_cs   <= 1'b0;
                tft_sck  <= 1'b0;
                tft_dc   <= tx_dc;
                tft_mosi <= tx_byte[7];
                shift    <= tx_byte[6:0];
            end else if (tail_end) begin
                busy     <= 1'b0;
                slot     <= '0;
                hcnt     <= '0;
                tft_dc   <= 1'b0;
                tft_mosi <= 1'b0;
            end else if (step) begin
                hcnt <= '0;
                slot <= slot + 5'd1;
                if (slot < 5'd15) begin
                    if (!slot[0]) begin
                        tft_sck <= 1'b1;
                    end else begin
                        tft_sck  <= 1'b0;
                        tft_mosi <= shift[6];
                        shift    <= {shift[5:0], 1'b0};
                    end
                end else if (slot == 5'd15) begin
                    tft_sck <= 1'b0;
                end else if (slot == 5'd16) begin
                    tft_cs <= 1'b1;
                end
            end else if (busy) begin
                hcnt <= hcnt + 8'd1;
            end

            case (state)
                StRstLow: begin
                    if (cnt == 32'(RST_LOW_CYC - 1)) begin
                        cnt     <= '0;
                        tft_rst <= 1'b1;
                        state   <= StRstWait;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                StRstWait: begin
                    if (cnt == 32'(RST_WAIT_CYC - 1)) begin
                        cnt   <= '0;
                        state <= StSleepOut;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                StSleepOut: if (cs_rise) state <= StSlpWait;
                StSlpWait: begin
                    if (!busy) begin
                        if (cnt == 32'(SLP_WAIT_CYC - 1)) begin
                            cnt   <= '0;
                            idx   <= '0;
                            state <= StInit;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                end
                StInit: begin
                    if (cs_rise) begin
                        if (idx == 4'd4) begin
                            idx   <= '0;
                            state <= StWindow;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                StWindow: begin
                    if (cs_rise) begin
                        if (idx == 4'd10) begin
                            idx    <= '0;
                            pix_lo <= 1'b0;
                            col    <= '0;
                            row    <= '0;
                            state  <= StFill;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                StFill: begin
                    if (cs_rise) begin
                        pix_lo <= !pix_lo;
                        if (pix_lo) begin
                            if (col == CW'(FILL_COLS - 1)) begin
                                col <= '0;
                                if (row == RW'(FILL_ROWS - 1)) begin
                                    state <= StDone;
                                end else begin
                                    row <= row + RW'(1);
                                end
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tft_top.sv
// Directed bench for tft_top: reset timing, command/data decode, SPI framing, fill and abort.
// Fill height is reduced to 2 rows so the whole run stays short; columns stay at 240.
module tb_tft_top;

    localparam int COLS = 240;
    localparam int ROWS = 2;
    localparam int NHDR = 17;
    localparam int NTOT = NHDR + COLS * ROWS * 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tft_cs, tft_sck, tft_rst, tft_dc, tft_mosi;

    int n_checks = 0;
    int n_pass   = 0;

    tft_top #(
        .RST_LOW_CYC (10),
        .RST_WAIT_CYC(20),
        .SLP_WAIT_CYC(20),
        .FILL_ROWS   (ROWS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tft_cs  (tft_cs),
        .tft_sck (tft_sck),
        .tft_rst (tft_rst),
        .tft_dc  (tft_dc),
        .tft_mosi(tft_mosi)
    );

    always #5 clk = ~clk;

    // Byte decoder: {dc, byte} pushed when cs rises after 8 sck rising edges.
    logic [8:0] rx_q[$];
    logic [7:0] rx_sh;
    logic       rx_dc;
    int         rx_nb = 0;

    always @(posedge tft_sck or posedge tft_cs or posedge rst) begin
        if (rst) begin
            rx_nb = 0;
        end else if (tft_cs) begin
            if (rx_nb == 8) rx_q.push_back({rx_dc, rx_sh});
            rx_nb = 0;
        end else begin
            rx_sh = {rx_sh[6:0], tft_mosi};
            rx_dc = tft_dc;
            rx_nb++;
        end
    end

    // Framing monitor, sampled mid-cycle.
    logic mon_en = 1'b1;
    logic p_cs = 1'b1, p_sck = 1'b0, p_mosi = 1'b0, p_dc = 1'b0;
    int low_len = 0, high_len = 0, low_cnt = 0, low_bad = 0, high_bad = 0;
    int sck_gap = 0, sck_bad = 0, mode0_bad = 0, dc_bad = 0;
    logic have_rise = 1'b0;

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (tft_cs) begin
                if (!p_cs) begin
                    if (low_len != 34) low_bad++;
                    low_cnt++;
                    high_len = 1;
                end else begin
                    high_len++;
                end
            end else begin
                if (p_cs) begin
                    if (low_cnt >= 2 && high_len != 4) high_bad++;
                    low_len   = 1;
                    have_rise = 1'b0;
                end else begin
                    low_len++;
                    if (tft_dc !== p_dc) dc_bad++;
                end
            end
            sck_gap++;
            if (tft_sck && !p_sck) begin
                if (have_rise && sck_gap != 4) sck_bad++;
                have_rise = 1'b1;
                sck_gap   = 0;
            end
            if (p_sck && tft_sck && tft_mosi !== p_mosi) mode0_bad++;
        end
        p_cs   = tft_cs;
        p_sck  = tft_sck;
        p_mosi = tft_mosi;
        p_dc   = tft_dc;
    end

    function automatic logic [8:0] exp_hdr(input int i);
        case (i)
            0: return 9'h011;   1: return 9'h03A;   2: return 9'h155;   3: return 9'h036;
            4: return 9'h148;   5: return 9'h029;   6: return 9'h02A;   7: return 9'h100;
            8: return 9'h100;   9: return 9'h100;  10: return 9'h1EF;  11: return 9'h02B;
            12: return 9'h100; 13: return 9'h100;  14: return 9'h101;  15: return 9'h13F;
            default: return 9'h02C;
        endcase
    endfunction

    function automatic logic [15:0] exp_color(input int c);
`ifdef TFT_COLOR_BAR_EN
        case (c / 30)
            0: return 16'hFFFF; 1: return 16'hFFE0; 2: return 16'h07FF; 3: return 16'h07E0;
            4: return 16'hF81F; 5: return 16'hF800; 6: return 16'h001F; default: return 16'h0000;
        endcase
`else
        return 16'hF800;
`endif
    endfunction

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        n_checks++;
        if (rx_q.size() < n) $display("FAIL wait_bytes: got %0d bytes, need %0d", rx_q.size(), n);
        else n_pass++;
    endtask

    task automatic check_rst_low(input string tag);
        int n = 0;
        @(negedge clk);
        rst = 1'b0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (tft_rst) break;
        end
        n_checks++;
        if (n !== 10) $display("FAIL %s tft_rst low cycles: got %0d, need 10", tag, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({tft_cs, tft_sck, tft_rst, tft_dc, tft_mosi} !== 5'b10000)
            $display("FAIL reset_outputs: got %b, need 10000",
                     {tft_cs, tft_sck, tft_rst, tft_dc, tft_mosi});
        else n_pass++;
        check_rst_low("reset");
    endtask

    task automatic test_header();
        wait_bytes(NHDR, 3000);
        for (int i = 0; i < NHDR; i++) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_hdr(i))
                $display("FAIL hdr_byte%0d: got %h, need %h", i,
                         (i < rx_q.size()) ? rx_q[i] : 9'h1FF, exp_hdr(i));
            else n_pass++;
        end
    endtask

    task automatic test_fill();
        int bad = 0;
        logic [15:0] px;
        int pidx[4] = '{0, 30, 239, 240};
`ifdef TFT_COLOR_BAR_EN
        logic [15:0] pexp[4] = '{16'hFFFF, 16'hFFE0, 16'h0000, 16'hFFFF};
`else
        logic [15:0] pexp[4] = '{16'hF800, 16'hF800, 16'hF800, 16'hF800};
`endif
        wait_bytes(NTOT, 50000);
        for (int j = 0; j < NTOT - NHDR && NHDR + j < rx_q.size(); j++) begin
            px = exp_color((j / 2) % COLS);
            if (rx_q[NHDR + j] !== {1'b1, (j % 2 == 1) ? px[7:0] : px[15:8]}) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL fill_bytes: got %0d wrong bytes, need 0", bad);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            px = 16'hxxxx;
            if (NHDR + 2 * pidx[k] + 1 < rx_q.size())
                px = {rx_q[NHDR + 2 * pidx[k]][7:0], rx_q[NHDR + 2 * pidx[k] + 1][7:0]};
            n_checks++;
            if (px !== pexp[k]) $display("FAIL pixel%0d: got %h, need %h", pidx[k], px, pexp[k]);
            else n_pass++;
        end
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (!tft_cs) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL done_cs_high: got %0d low cycles, need 0", bad);
        else n_pass++;
        n_checks++;
        if ({tft_cs, tft_sck, tft_rst, tft_dc, tft_mosi} !== 5'b10100)
            $display("FAIL done_outputs: got %b, need 10100",
                     {tft_cs, tft_sck, tft_rst, tft_dc, tft_mosi});
        else n_pass++;
        n_checks++;
        if (rx_q.size() !== NTOT) $display("FAIL byte_count: got %0d, need %0d", rx_q.size(), NTOT);
        else n_pass++;
    endtask

    task automatic test_framing();
        n_checks++;
        if (low_cnt !== NTOT) $display("FAIL cs_windows: got %0d, need %0d", low_cnt, NTOT);
        else n_pass++;
        n_checks++;
        if (low_bad !== 0) $display("FAIL cs_low_34: got %0d bad windows, need 0", low_bad);
        else n_pass++;
        n_checks++;
        if (high_bad !== 0) $display("FAIL cs_high_4: got %0d bad gaps, need 0", high_bad);
        else n_pass++;
        n_checks++;
        if (sck_bad !== 0) $display("FAIL sck_period_4: got %0d bad periods, need 0", sck_bad);
        else n_pass++;
        n_checks++;
        if (mode0_bad !== 0) $display("FAIL mosi_sck_high: got %0d changes, need 0", mode0_bad);
        else n_pass++;
        n_checks++;
        if (dc_bad !== 0) $display("FAIL dc_stable: got %0d changes, need 0", dc_bad);
        else n_pass++;
    endtask

    task automatic test_abort();
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        rx_q.delete();
        @(negedge clk);
        rst = 1'b0;
        wait_bytes(NHDR + 20, 3000);
        // Land mid-byte, off the clock edge.
        begin
            int k = 0;
            while (!(tft_cs === 1'b0 && tft_sck === 1'b1) && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({tft_cs, tft_sck, tft_rst, tft_dc, tft_mosi} !== 5'b10000)
            $display("FAIL abort_async_outputs: got %b, need 10000",
                     {tft_cs, tft_sck, tft_rst, tft_dc, tft_mosi});
        else n_pass++;
        repeat (5) @(posedge clk);
        rx_q.delete();
        check_rst_low("abort");
        wait_bytes(1, 500);
        n_checks++;
        if (rx_q.size() == 0 || rx_q[0] !== 9'h011)
            $display("FAIL abort_first_byte: got %h, need 011",
                     (rx_q.size() > 0) ? rx_q[0] : 9'h1FF);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_header();
        test_fill();
        test_framing();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tft_top.md
TFT_TOP -- requirements
Module: tft_top

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency; informational only.
REQ-002 SHALL have parameter SCK_HALF, default 2, clk cycles per SCK half-period (SCK = clk/4 = 12.5 MHz).
REQ-003 SHALL have parameter RST_LOW_CYC, default 1_000, clk cycles tft_rst is held low after reset (20 us).
REQ-004 SHALL have parameter RST_WAIT_CYC, default 250_000, clk cycles waited after tft_rst rises (5 ms).
REQ-005 SHALL have parameter SLP_WAIT_CYC, default 250_000, clk cycles waited after command 0x11 (5 ms).
REQ-006 SHALL have parameter FILL_COLOR, default 16'hF800, RGB565 fill colour.
REQ-007 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port tft_cs, output, 1, SPI chip select, active low.
REQ-010 SHALL have port tft_sck, output, 1, SPI clock, idle low.
REQ-011 SHALL have port tft_rst, output, 1, panel hardware reset, active low.
REQ-012 SHALL have port tft_dc, output, 1, 0 = command byte, 1 = data byte.
REQ-013 SHALL have port tft_mosi, output, 1, serial data, MSB first.

Function
REQ-014 SHALL use SPI mode 0: tft_mosi changes only while tft_sck low; tft_sck high for SCK_HALF cycles, then low for SCK_HALF cycles, per bit.
REQ-015 SHALL send each byte as: tft_cs and tft_dc set low/valid, SCK_HALF cycles setup, 8 bits, tft_cs high for exactly 2*SCK_HALF cycles before the next byte; tft_dc is stable for the whole low-cs window.
REQ-016 SHALL sequence states RST_LOW -> RST_WAIT -> SLEEP_OUT -> SLP_WAIT -> INIT -> WINDOW -> FILL -> DONE.
REQ-017 In RST_LOW, SHALL drive tft_rst=0 for RST_LOW_CYC cycles; then tft_rst=1 for the rest of operation.
REQ-018 SLEEP_OUT SHALL send command 0x11; SLP_WAIT SHALL idle (cs high) SLP_WAIT_CYC cycles.
REQ-019 INIT SHALL send, in order: cmd 0x3A, data 0x55; cmd 0x36, data 0x48; cmd 0x29.
REQ-020 WINDOW SHALL send: cmd 0x2A, data 0x00 0x00 0x00 0xEF; cmd 0x2B, data 0x00 0x00 0x01 0x3F; cmd 0x2C.
REQ-021 FILL SHALL send 240x320 = 76_800 pixels, two data bytes each, high byte first, column counter 0..239 wrapping to 0 and incrementing a row counter 0..319.
REQ-022 After pixel 76_799 SHALL enter DONE: tft_cs=1, tft_sck=0, tft_dc=0, tft_mosi=0, tft_rst=1, held until rst.
REQ-023 All outputs SHALL be registered; no combinational path from rst to outputs other than asynchronous clear.

Reset
REQ-024 While rst=1: tft_cs=1, tft_sck=0, tft_rst=0, tft_dc=0, tft_mosi=0, state=RST_LOW, all counters 0.
REQ-025 rst asserted mid-byte or mid-fill SHALL abort immediately; after release the full sequence restarts from RST_LOW.

Configuration
REQ-026 With macro TFT_COLOR_BAR_EN defined, FILL pixel colour SHALL be bar (column/30) of: 0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000.
REQ-027 Without TFT_COLOR_BAR_EN, every pixel SHALL be FILL_COLOR.

Verification (bench overrides RST_LOW_CYC=10, RST_WAIT_CYC=20, SLP_WAIT_CYC=20)
REQ-028 rst high 5 cycles then low -> outputs at reset values; tft_rst low exactly 10 cycles after release, then high.
REQ-029 Sample tft_mosi on tft_sck rising edges while tft_cs low -> first byte 0x11 with dc=0; next bytes 0x3A(dc0) 0x55(dc1) 0x36 0x48 0x29.
REQ-030 Measure byte framing -> tft_sck period 4 clk, tft_cs low 34 clk per byte, high 4 clk between bytes.
REQ-031 Decode WINDOW -> 0x2A 00 00 00 EF, 0x2B 00 00 01 3F, 0x2C; then 153_600 data bytes, all 0xF8,0x00 (macro off), then tft_cs stays high.
REQ-032 Macro on -> pixel 0 = 0xFFFF, pixel 30 = 0xFFE0, pixel 239 = 0x0000, pixel 240 = 0xFFFF.
REQ-033 Assert rst during FILL pixel 1000 -> outputs reset asynchronously; after release sequence restarts with tft_rst low and first byte 0x11.
